// File: rtl/field_vga_renderer_if.sv
// Playfield-to-VGA bus: occupancy grid from the field logic, DAC/sync pins back out.
// The renderer takes the slave side; whoever owns the field and pins takes master.
interface field_vga_renderer_if;
  logic [99:0] fieldIn;
  logic        hsync;
  logic        vsync;
  logic        videoOn;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frameStart;

  modport master (
    output fieldIn,
    input  hsync, vsync, videoOn, red, green, blue, frameStart
  );

  modport slave (
    input  fieldIn,
    output hsync, vsync, videoOn, red, green, blue, frameStart
  );
endinterface

// File: rtl/field_vga_renderer.sv
// Scans a VGA raster and paints the 10x10 playfield as square cells, snapshotting the field in vblank.
// Optional macro GRID_LINES_EN: empty cells show a grey line on their top row and left column.
module field_vga_renderer #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          CELL_LOG2 = 5,
  parameter int          GRID_X0   = 160,
  parameter int          GRID_Y0   = 80,
  parameter logic [11:0] FILL_RGB  = 12'hF80
) (
  input  logic                  clock,
  input  logic                  reset,
  field_vga_renderer_if.slave   vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GRID_W  = 10 << CELL_LOG2;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] GX_LO    = HW'(GRID_X0);
  localparam logic [HW-1:0] GX_HI    = HW'(GRID_X0 + GRID_W);
  localparam logic [HW-1:0] GX_RING  = HW'(GRID_X0 - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] GY_LO    = VW'(GRID_Y0);
  localparam logic [VW-1:0] GY_HI    = VW'(GRID_Y0 + GRID_W);
  localparam logic [VW-1:0] GY_RING  = VW'(GRID_Y0 - 1);

  function automatic logic [11:0] pixel_colour(
    input logic vis,
    input logic in_grid,
    input logic occupied,
    input logic grid_line,
    input logic border
  );
    if (!vis)                        return 12'h000;
    else if (in_grid && occupied)    return FILL_RGB;
    else if (in_grid && grid_line)   return 12'h444;
    else if (border)                 return 12'hFFF;
    else                             return 12'h000;
  endfunction

  // ---- S0: raster counters and field snapshot
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [99:0]   snap_q, snap_d;

  always_comb begin
    hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    snap_d = (hcnt_q == '0 && vcnt_q == V_VIS) ? vga.fieldIn : snap_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      snap_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      snap_q <= snap_d;
    end
  end

  // ---- S1: region classification and cell coordinates
  logic          in_grid_p1_d, in_grid_p1_q;
  logic          border_p1_d,  border_p1_q;
  logic          vld_p1_d,     vld_p1_q;
  logic          hs_p1_d,      hs_p1_q;
  logic          vs_p1_d,      vs_p1_q;
  logic          first_p1_d,   first_p1_q;
  logic [3:0]    col_p1_d,     col_p1_q;
  logic [3:0]    row_p1_d,     row_p1_q;
  logic [HW-1:0] dx_p0;
  logic [VW-1:0] dy_p0;
  logic          ring_x_p0, ring_y_p0;

  always_comb begin
    in_grid_p1_d = (hcnt_q >= GX_LO) && (hcnt_q < GX_HI) &&
                   (vcnt_q >= GY_LO) && (vcnt_q < GY_HI);
    ring_x_p0    = (hcnt_q >= GX_RING) && (hcnt_q <= GX_HI);
    ring_y_p0    = (vcnt_q >= GY_RING) && (vcnt_q <= GY_HI);
    border_p1_d  = ring_x_p0 && ring_y_p0 && !in_grid_p1_d;
    // Offsets are forced to zero off-grid so the subtraction never wraps.
    dx_p0        = in_grid_p1_d ? hcnt_q - GX_LO : '0;
    dy_p0        = in_grid_p1_d ? vcnt_q - GY_LO : '0;
    col_p1_d     = 4'(dx_p0 >> CELL_LOG2);
    row_p1_d     = 4'(dy_p0 >> CELL_LOG2);
    vld_p1_d     = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    hs_p1_d      = !((hcnt_q >= HS_BEG) && (hcnt_q <= HS_END));
    vs_p1_d      = !((vcnt_q >= VS_BEG) && (vcnt_q <= VS_END));
    first_p1_d   = (hcnt_q == '0) && (vcnt_q == '0);
  end

`ifdef GRID_LINES_EN
  localparam logic [HW-1:0] X_MASK = HW'((1 << CELL_LOG2) - 1);
  localparam logic [VW-1:0] Y_MASK = VW'((1 << CELL_LOG2) - 1);
  logic line_p1_d, line_p1_q;

  assign line_p1_d = in_grid_p1_d &&
                     (((dx_p0 & X_MASK) == '0) || ((dy_p0 & Y_MASK) == '0));

  always_ff @(posedge clock) begin
    if (reset) line_p1_q <= 1'b0;
    else       line_p1_q <= line_p1_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      in_grid_p1_q <= 1'b0;
      border_p1_q  <= 1'b0;
      vld_p1_q     <= 1'b0;
      hs_p1_q      <= 1'b1;
      vs_p1_q      <= 1'b1;
      first_p1_q   <= 1'b0;
      col_p1_q     <= '0;
      row_p1_q     <= '0;
    end else begin
      in_grid_p1_q <= in_grid_p1_d;
      border_p1_q  <= border_p1_d;
      vld_p1_q     <= vld_p1_d;
      hs_p1_q      <= hs_p1_d;
      vs_p1_q      <= vs_p1_d;
      first_p1_q   <= first_p1_d;
      col_p1_q     <= col_p1_d;
      row_p1_q     <= row_p1_d;
    end
  end

  // ---- S2: cell lookup, colour and aligned pin outputs
  logic [6:0]  idx_p1;
  logic        grid_line_p1;
  logic [11:0] rgb_p2_d, rgb_p2_q;
  logic        hs_p2_q, vs_p2_q, vld_p2_q, fs_p2_q;

  always_comb begin
    idx_p1 = 7'(row_p1_q) * 7'd10 + 7'(col_p1_q);
`ifdef GRID_LINES_EN
    grid_line_p1 = line_p1_q;
`else
    grid_line_p1 = 1'b0;
`endif
    rgb_p2_d = pixel_colour(vld_p1_q, in_grid_p1_q, snap_q[idx_p1], grid_line_p1, border_p1_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_p2_q <= '0;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
      vld_p2_q <= 1'b0;
      fs_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
      vld_p2_q <= vld_p1_q;
      fs_p2_q  <= first_p1_q;
    end
  end

  assign vga.red        = rgb_p2_q[11:8];
  assign vga.green      = rgb_p2_q[7:4];
  assign vga.blue       = rgb_p2_q[3:0];
  assign vga.hsync      = hs_p2_q;
  assign vga.vsync      = vs_p2_q;
  assign vga.videoOn    = vld_p2_q;
  assign vga.frameStart = fs_p2_q;

endmodule

// File: tb/tb_field_vga_renderer.sv
// Bench for field_vga_renderer on a shrunken raster (36x32 total, 2-pixel cells) so frames are short.
// Probes are queued with hand-derived colours; a negedge monitor tracks the output raster and checks them.
module tb_field_vga_renderer;
  localparam int HV = 28, HF = 2, HS = 4, HB = 2;
  localparam int VV = 26, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [11:0] FILL = 12'hF80;
  localparam logic [11:0] WHT  = 12'hFFF;
`ifdef GRID_LINES_EN
  localparam logic [11:0] GREY = 12'h444;
`else
  localparam logic [11:0] GREY = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  field_vga_renderer_if vif();

  field_vga_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CELL_LOG2(1), .GRID_X0(4), .GRID_Y0(3), .FILL_RGB(FILL)
  ) dut (
    .clock (clk),
    .reset (rst),
    .vga   (vif)
  );

  wire [11:0] rgb = {vif.red, vif.green, vif.blue};

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [11:0] c;
    logic        hs;
    logic        vs;
    logic        von;
  } probe_t;

  probe_t q[$];
  int n_cmp = 0, n_fail = 0;
  int mon_f = -1, mon_x = 0, mon_y = 0;
  int cyc_cnt = 0, vid_cnt = 0, vio = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int f, input int x, input int y, input logic [11:0] c,
                      input logic hs, input logic vs, input logic von);
    probe_t p;
    p.f = f; p.x = x; p.y = y; p.c = c; p.hs = hs; p.vs = vs; p.von = von;
    q.push_back(p);
  endtask

  task automatic pix(input int f, input int x, input int y, input logic [11:0] c);
    push(f, x, y, c, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic wait_pos(input int f, input int y, input int x);
    int n;
    n = 0;
    while (!(mon_f == f && mon_y == y && mon_x >= x) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_pos f%0d y%0d: raster position never reached, now f%0d y%0d", f, y, mon_f, mon_y);
    end
  endtask

  // Monitor: follows the output raster from frameStart and checks queued probes.
  always @(negedge clk) begin
    if (!rst) begin
      if (vif.frameStart) begin
        if (mon_f >= 1 && mon_f <= 3) begin
          check($sformatf("frame_len f%0d", mon_f), cyc_cnt, HT * VT);
          check($sformatf("videoOn_count f%0d", mon_f), vid_cnt, HV * VV);
        end
        mon_f++;
        mon_x = 0;
        mon_y = 0;
        cyc_cnt = 0;
        vid_cnt = 0;
      end else if (mon_f >= 0) begin
        mon_x++;
        if (mon_x == HT) begin
          mon_x = 0;
          mon_y++;
        end
      end
      cyc_cnt++;
      if (vif.videoOn) vid_cnt++;
      if (!vif.videoOn && rgb != 12'h000) vio++;
      if (q.size() > 0 && q[0].f == mon_f && q[0].x == mon_x && q[0].y == mon_y) begin
        probe_t p;
        p = q.pop_front();
        check($sformatf("rgb f%0d (%0d,%0d)", p.f, p.x, p.y), rgb, p.c);
        check($sformatf("hsync f%0d (%0d,%0d)", p.f, p.x, p.y), vif.hsync, p.hs);
        check($sformatf("vsync f%0d (%0d,%0d)", p.f, p.x, p.y), vif.vsync, p.vs);
        check($sformatf("videoOn f%0d (%0d,%0d)", p.f, p.x, p.y), vif.videoOn, p.von);
      end
    end
  end

  initial begin
    int cyc, low, adv, n;
    rst = 1'b1;
    vif.fieldIn = '0;
    vif.fieldIn[0] = 1'b1;

    // Frame 0: snapshot still cleared, only the border ring shows; sync/blank edges.
    pix(0, 0, 0, 12'h000);
    pix(0, 3, 2, WHT);
    pix(0, 4, 2, WHT);
    pix(0, 2, 3, 12'h000);
    pix(0, 3, 3, WHT);
    pix(0, 4, 3, GREY);
    pix(0, 24, 3, WHT);
    pix(0, 25, 3, 12'h000);
    push(0, 27, 5, 12'h000, 1, 1, 1);
    push(0, 28, 5, 12'h000, 1, 1, 0);
    push(0, 29, 5, 12'h000, 1, 1, 0);
    push(0, 30, 5, 12'h000, 0, 1, 0);
    push(0, 33, 5, 12'h000, 0, 1, 0);
    push(0, 34, 5, 12'h000, 1, 1, 0);
    pix(0, 4, 23, WHT);
    pix(0, 4, 24, 12'h000);
    push(0, 0, 25, 12'h000, 1, 1, 1);
    push(0, 0, 26, 12'h000, 1, 1, 0);
    push(0, 0, 27, 12'h000, 1, 1, 0);
    push(0, 0, 28, 12'h000, 1, 0, 0);
    push(0, 35, 29, 12'h000, 1, 0, 0);
    push(0, 0, 30, 12'h000, 1, 1, 0);
    // Frame 1: cell 0 filled; field goes all-ones mid-frame but stays invisible.
    pix(1, 4, 3, FILL);
    pix(1, 6, 3, GREY);
    pix(1, 5, 4, FILL);
    pix(1, 4, 5, GREY);
    pix(1, 7, 6, 12'h000);
    pix(1, 23, 20, 12'h000);
    // Frame 2: every cell filled.
    pix(2, 4, 3, FILL);
    pix(2, 23, 3, FILL);
    pix(2, 24, 3, WHT);
    pix(2, 13, 12, FILL);
    pix(2, 4, 22, FILL);
    pix(2, 23, 22, FILL);
    pix(2, 24, 22, WHT);
    pix(2, 23, 23, WHT);
    // Frame 3: only cell 99 filled.
    pix(3, 5, 4, 12'h000);
    pix(3, 22, 21, FILL);
    pix(3, 24, 21, WHT);
    pix(3, 21, 22, 12'h000);
    pix(3, 23, 22, FILL);
    pix(3, 22, 23, WHT);

    repeat (3) begin
      @(posedge clk); #1;
      check("reset hsync", vif.hsync, 1);
      check("reset vsync", vif.vsync, 1);
      check("reset videoOn", vif.videoOn, 0);
      check("reset rgb", rgb, 0);
      check("reset frameStart", vif.frameStart, 0);
    end
    rst = 1'b0;

    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (vif.hsync && cyc < 200);
    check("hsync first fall cycle", cyc, 2 + HV + HF);
    low = 0;
    while (!vif.hsync && low < 200) begin
      @(posedge clk); #1;
      low++;
    end
    check("hsync low width", low, HS);
    adv = 0;
    while (vif.hsync && adv < 200) begin
      @(posedge clk); #1;
      adv++;
    end
    check("line period", low + adv, HT);

    wait_pos(1, 10, 0);
    vif.fieldIn = '1;
    wait_pos(2, 10, 0);
    vif.fieldIn = '0;
    vif.fieldIn[99] = 1'b1;

    // Mid-line reset in frame 4.
    wait_pos(4, 10, 15);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset hsync", vif.hsync, 1);
    check("midreset vsync", vif.vsync, 1);
    check("midreset videoOn", vif.videoOn, 0);
    check("midreset rgb", rgb, 0);
    check("midreset frameStart", vif.frameStart, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("frameStart 1 cycle after release", vif.frameStart, 0);
    @(posedge clk); #1;
    check("frameStart 2 cycles after release", vif.frameStart, 1);

    // Frame 5 starts from a cleared snapshot; frame 6 shows cell 99 again.
    pix(5, 24, 21, WHT);
    pix(5, 23, 22, 12'h000);
    pix(6, 22, 21, FILL);
    pix(6, 23, 22, FILL);

    n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    while (q.size() > 0) begin
      probe_t p;
      p = q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL probe f%0d (%0d,%0d): never observed, required rgb %03h", p.f, p.x, p.y, p.c);
    end
    check("rgb nonzero while blanked", vio, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
